// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM state constants and word geometry for data_mem_ctrl
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic [1:0] dmem_state_t;

  localparam dmem_state_t ST_IDLE   = 2'd0;
  localparam dmem_state_t ST_ACCESS = 2'd1;
  localparam dmem_state_t ST_RESP   = 2'd2;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte enables, store-data lane steering and load extension
// Lane k of a word is the byte at (word base + k), held in bits [DATA_W-1-8k -: 8] (big-endian).
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BPW    = DATA_W / 8,
  localparam int OFF_W  = $clog2(BPW)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [BPW-1:0]    be,
  output logic [DATA_W-1:0] wword,
  output logic [DATA_W-1:0] rdata
);

  logic [OFF_W-1:0] half_base;
  logic [7:0]       byte_sel;
  logic [7:0]       half_hi;
  logic [7:0]       half_lo;

  assign half_base = offset & ~OFF_W'(1);

  always_comb begin
    be       = '0;
    wword    = '0;
    rdata    = '0;
    byte_sel = '0;
    half_hi  = '0;
    half_lo  = '0;
    for (int k = 0; k < BPW; k++) begin
      if (OFF_W'(k) == offset)                   byte_sel = rword[DATA_W-1-8*k -: 8];
      if (OFF_W'(k) == half_base)                half_hi  = rword[DATA_W-1-8*k -: 8];
      if (OFF_W'(k) == (half_base | OFF_W'(1)))  half_lo  = rword[DATA_W-1-8*k -: 8];
      // Store data is replicated into every candidate lane; be picks the live ones.
      case (size)
        SZ_BYTE: begin
          be[k]                    = (OFF_W'(k) == offset);
          wword[DATA_W-1-8*k -: 8] = wdata[7:0];
        end
        SZ_HALF: begin
          be[k]                    = ((OFF_W'(k) & ~OFF_W'(1)) == half_base);
          wword[DATA_W-1-8*k -: 8] = ((k % 2) == 0) ? wdata[15:8] : wdata[7:0];
        end
        default: begin
          be[k]                    = 1'b1;
          wword[DATA_W-1-8*k -: 8] = wdata[DATA_W-1-8*k -: 8];
        end
      endcase
    end
    case (size)
      SZ_BYTE: rdata = {{(DATA_W-8){byte_sel[7] & ~uns}}, byte_sel};
      SZ_HALF: rdata = {{(DATA_W-16){half_hi[7] & ~uns}}, half_hi, half_lo};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - handshaked big-endian byte-addressed data memory, one transaction in flight
// Optional fault checking (misalignment, out-of-range) enabled by defining DMEM_ERR_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 8 * BYTES_PER_WORD,
  parameter int DEPTH_BYTES = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] DataOut,
  output logic              err
);

  localparam int BPW    = DATA_W / 8;
  localparam int OFF_W  = $clog2(BPW);
  localparam int NWORDS = DEPTH_BYTES / BPW;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  dmem_state_t       state_q,   state_d;
  logic              we_q,      we_d;
  logic [1:0]        size_q,    size_d;
  logic              uns_q,     uns_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              err_q,     err_d;

  logic [DATA_W-1:0] mem_q [NWORDS];

  logic [ADDR_W-1:0] eff_addr;
  logic [WIDX_W-1:0] widx;
  logic [OFF_W-1:0]  raw_off;
  logic [OFF_W-1:0]  offset;
  logic              fault;
  logic [BPW-1:0]    be;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] rdata;
  logic              wr_en;

  assign eff_addr = addr_q % ADDR_W'(DEPTH_BYTES);
  assign widx     = WIDX_W'(eff_addr >> OFF_W);
  assign raw_off  = eff_addr[OFF_W-1:0];
  assign rword    = mem_q[widx];

`ifdef DMEM_ERR_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_q[0];
      default: misaligned = |addr_q[OFF_W-1:0];
    endcase
  end

  assign fault  = misaligned | (addr_q >= ADDR_W'(DEPTH_BYTES));
  assign offset = raw_off;
`else
  assign fault = 1'b0;

  // Without checking, low address bits are dropped to the natural alignment of the size.
  always_comb begin
    offset = raw_off;
    case (size_q)
      SZ_BYTE: offset = raw_off;
      SZ_HALF: offset = raw_off & ~OFF_W'(1);
      default: offset = '0;
    endcase
  end
`endif

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .size   (size_q),
    .uns    (uns_q),
    .offset (offset),
    .wdata  (wdata_q),
    .rword  (rword),
    .be     (be),
    .wword  (wword),
    .rdata  (rdata)
  );

  // Gated by state_q, which reset clears asynchronously, so a reset never lets a store land.
  assign wr_en = (state_q == ST_ACCESS) && we_q && !fault;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int k = 0; k < BPW; k++) begin
        if (be[k]) mem_q[widx][DATA_W-1-8*k -: 8] <= wword[DATA_W-1-8*k -: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dataout_d = dataout_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          addr_d  = Address;
          wdata_d = WriteData;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        dataout_d = (we_q || fault) ? '0 : rdata;
        err_d     = fault;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dataout_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dataout_q <= dataout_d;
      err_q     <= err_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign DataOut    = dataout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed vector bench for data_mem_ctrl (default or DMEM_ERR_EN build)
module tb_data_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              CLK;
  logic              nRST;
  logic              req;
  logic              ready;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] DataOut;
  logic              err;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req        (req),
    .ready      (ready),
    .we         (we),
    .size       (size),
    .uns        (uns),
    .Address    (Address),
    .WriteData  (WriteData),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .DataOut    (DataOut),
    .err        (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ed,
                     input logic ee);
    vec_t v;
    v.name = n; v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic timeout(input string n);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got 0, expected 1", n);
  endtask

  // Drives one request from a negedge and returns the sampled response.
  task automatic do_tx(input string n, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int cnt;
    d = '0; e = 1'b0;
    cnt = 0;
    while (!ready && cnt < 20) begin @(negedge CLK); cnt++; end
    if (!ready) begin timeout({n, " ready"}); return; end
    req = 1'b1; we = w; size = sz; uns = u; Address = a; WriteData = wd;
    @(posedge CLK); #1;
    req = 1'b0;
    check({n, " access busy"}, {30'd0, ready, resp_valid}, 32'd0);
    cnt = 0;
    while (!resp_valid && cnt < 20) begin @(negedge CLK); cnt++; end
    if (!resp_valid) begin timeout({n, " resp_valid"}); return; end
    d = DataOut;
    e = err;
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    @(negedge CLK);
  endtask

  logic [31:0] d;
  logic        e;
  int          cnt;

  initial begin
    nRST = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    Address = '0; WriteData = '0; resp_ready = 1'b0;

    add("sw 10",        1, 2'b10, 0, 32'h10, 32'h8899AABB, 32'h0,        0);
    add("lw 10",        0, 2'b10, 0, 32'h10, 32'h0,        32'h8899AABB, 0);
    add("lbu 10",       0, 2'b00, 1, 32'h10, 32'h0,        32'h00000088, 0);
    add("lb 13",        0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFBB, 0);
    add("lb 10",        0, 2'b00, 0, 32'h10, 32'h0,        32'hFFFFFF88, 0);
    add("lbu 11",       0, 2'b00, 1, 32'h11, 32'h0,        32'h00000099, 0);
    add("lhu 12",       0, 2'b01, 1, 32'h12, 32'h0,        32'h0000AABB, 0);
    add("lh 12",        0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFAABB, 0);
    add("lh 10",        0, 2'b01, 0, 32'h10, 32'h0,        32'hFFFF8899, 0);
    add("sw 20 clr",    1, 2'b10, 0, 32'h20, 32'h0,        32'h0,        0);
    add("sh 22",        1, 2'b01, 0, 32'h22, 32'hFFFF1234, 32'h0,        0);
    add("lw 20",        0, 2'b10, 0, 32'h20, 32'h0,        32'h00001234, 0);
    add("lh 22",        0, 2'b01, 0, 32'h22, 32'h0,        32'h00001234, 0);
    add("sb 21",        1, 2'b00, 0, 32'h21, 32'hFFFFFF5A, 32'h0,        0);
    add("lw 20 sb",     0, 2'b10, 0, 32'h20, 32'h0,        32'h005A1234, 0);
    add("lbu 23",       0, 2'b00, 1, 32'h23, 32'h0,        32'h00000034, 0);
    add("size3 lw 10",  0, 2'b11, 0, 32'h10, 32'h0,        32'h8899AABB, 0);
`ifdef DMEM_ERR_EN
    add("sw 11 fault",  1, 2'b10, 0, 32'h11, 32'h11223344, 32'h0,        1);
    add("lw 10 intact", 0, 2'b10, 0, 32'h10, 32'h0,        32'h8899AABB, 0);
    add("lw depth",     0, 2'b10, 0, DEPTH,  32'h0,        32'h0,        1);
    add("lh 11 fault",  0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1);
    add("sb depth",     1, 2'b00, 0, DEPTH+4,32'hEE,       32'h0,        1);
`else
    add("sw wrap",      1, 2'b10, 0, DEPTH+4,32'hCAFEF00D, 32'h0,        0);
    add("lw 04",        0, 2'b10, 0, 32'h04, 32'h0,        32'hCAFEF00D, 0);
    add("lw 13 align",  0, 2'b10, 0, 32'h13, 32'h0,        32'h8899AABB, 0);
    add("lhu 13 align", 0, 2'b01, 1, 32'h13, 32'h0,        32'h0000AABB, 0);
`endif

    @(negedge CLK);
    check("reset ready",      {31'd0, ready},      32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset DataOut",    DataOut,             32'd0);
    check("reset err",        {31'd0, err},        32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      do_tx(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, d, e);
      check({vecs[i].name, " data"}, d, vecs[i].exp_data);
      check({vecs[i].name, " err"}, {31'd0, e}, {31'd0, vecs[i].exp_err});
    end

    // Backpressure: response must hold and a competing store must be ignored.
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; Address = 32'h20; WriteData = '0;
    @(posedge CLK); #1;
    we = 1'b1; WriteData = 32'hDEADBEEF;
    cnt = 0;
    while (!resp_valid && cnt < 20) begin @(negedge CLK); cnt++; end
    if (!resp_valid) timeout("bp resp_valid");
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("bp resp_valid held", {31'd0, resp_valid}, 32'd1);
      check("bp ready low",       {31'd0, ready},      32'd0);
      check("bp DataOut held",    DataOut,             32'h005A1234);
    end
    req = 1'b0;
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    @(negedge CLK);
    do_tx("bp lw 20 after", 0, 2'b10, 0, 32'h20, 32'h0, d, e);
    check("bp lw 20 after data", d, 32'h005A1234);

    // Reset asserted while a response is pending.
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; Address = 32'h10;
    @(posedge CLK); #1;
    req = 1'b0;
    cnt = 0;
    while (!resp_valid && cnt < 20) begin @(negedge CLK); cnt++; end
    if (!resp_valid) timeout("rst resp_valid");
    check("rst pre DataOut", DataOut, 32'h8899AABB);
    nRST = 1'b0;
    #1;
    check("rst ready",      {31'd0, ready},      32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst DataOut",    DataOut,             32'd0);
    check("rst err",        {31'd0, err},        32'd0);
    @(posedge CLK); #1;
    check("rst hold resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    do_tx("post rst lw 10", 0, 2'b10, 0, 32'h10, 32'h0, d, e);
    check("post rst lw 10 data", d, 32'h8899AABB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
